// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx between N_REQ byte producers.
// Enforces the done-to-valid guard the transmitter needs and releases a stalled owner on timeout.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TX_TIMEOUT = 8192
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_byte,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_tx_dv,
  output logic [7:0]         o_tx_byte,
  input  logic               i_tx_active,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TX_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_WAIT_NEXT,
    S_GUARD
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               lock_q, lock_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gok_q, gok_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic [7:0]         byte_q, byte_d;
  logic               dv_q, dv_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;

  logic [7:0]         lane [N_REQ];
  logic               rr_found;
  logic [PTR_W-1:0]   rr_winner;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   ptr_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               tmo_hit;

  // Transmitter activity is observational only; stalls are caught by the timeout.
  logic unused_tx_active;
  assign unused_tx_active = i_tx_active;

  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    assign lane[k] = i_req_byte[8*k +: 8];
  end

  assign ptr_next = (owner_q == PTR_W'(N_REQ-1)) ? '0 : owner_q + PTR_W'(1);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign tmo_hit  = (cnt_inc == CNT_W'(TX_TIMEOUT-1));

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!rr_found && i_req_valid[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    gok_d   = gok_q;
    grant_d = grant_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ready_d = '0;
    tmo_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          owner_d            = rr_winner;
          grant_d            = '0;
          grant_d[rr_winner] = 1'b1;
          byte_d             = lane[rr_winner];
          lock_d             = !i_req_last[rr_winner];
          dv_d               = 1'b1;
          ready_d[rr_winner] = 1'b1;
          state_d            = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_inc;
        if (i_tx_done) begin
          if (lock_q) begin
            gok_d   = 1'b0;
            state_d = S_WAIT_NEXT;
          end else begin
            ptr_d   = ptr_next;
            grant_d = '0;
            state_d = S_GUARD;
          end
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = S_GUARD;
        end
      end
      S_WAIT_NEXT: begin
        // gok_q rises on the second cycle after done, keeping dv at least 3 cycles after it.
        cnt_d = cnt_inc;
        gok_d = 1'b1;
        if (gok_q && i_req_valid[owner_q]) begin
          byte_d           = lane[owner_q];
          lock_d           = !i_req_last[owner_q];
          dv_d             = 1'b1;
          ready_d[owner_q] = 1'b1;
          state_d          = S_LAUNCH;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      gok_q   <= 1'b0;
      grant_q <= '0;
      ready_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      gok_q   <= gok_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_grant     = grant_q;
  assign o_tx_dv     = dv_q;
  assign o_tx_byte   = byte_q;
  assign o_busy      = busy_q;
  assign o_timeout   = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the transmitter's done pulse is driven by hand,
// so every grant, guard gap and timeout cycle is checked against hand-derived values.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  grant;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done;
  logic          busy;
  logic          timeout;

  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] ready_seen;
  logic [N-1:0] exp_oh;

  uart_tx_arbiter #(.N_REQ(N), .TX_TIMEOUT(TMO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_byte  (req_byte),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_grant     (grant),
    .o_tx_dv     (tx_dv),
    .o_tx_byte   (tx_byte),
    .i_tx_active (tx_active),
    .i_tx_done   (tx_done),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'h0);
    chk({tag, ".dv"}, 32'(tx_dv), 32'h0);
    chk({tag, ".byte"}, 32'(tx_byte), 32'h0);
    chk({tag, ".ready"}, 32'(req_ready), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".timeout"}, 32'(timeout), 32'h0);
  endtask

  task automatic chk_launch(input string tag, input logic [N-1:0] oh, input logic [7:0] b);
    chk({tag, ".dv"}, 32'(tx_dv), 32'h1);
    chk({tag, ".ready"}, 32'(req_ready), 32'(oh));
    chk({tag, ".grant"}, 32'(grant), 32'(oh));
    chk({tag, ".byte"}, 32'(tx_byte), 32'(b));
  endtask

  // Done asserted for one cycle; returns in the cycle after the done cycle.
  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_active = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_byte = '0;
    req_last = '0;
    tx_active = 1'b0;
    tx_done = 1'b0;
    #1;
    chk_all_zero("reset_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("reset_idle");

    // Single byte from requester 1.
    req_valid = 4'b0010;
    req_byte[15:8] = 8'h55;
    req_last = 4'b0010;
    tick();
    chk_launch("single", 4'b0010, 8'h55);
    chk("single.busy", 32'(busy), 32'h1);
    req_valid = '0;
    tx_active = 1'b1;
    tick();
    chk("single.dv_drop", 32'(tx_dv), 32'h0);
    chk("single.ready_drop", 32'(req_ready), 32'h0);
    pulse_done();
    chk("single.grant_rel", 32'(grant), 32'h0);
    tick();
    chk("single.idle", 32'(busy), 32'h0);

    // Pointer now 2: req2 beats req0 and keeps the grant for its 3-byte packet.
    req_byte[7:0] = 8'h11;
    req_byte[23:16] = 8'hA1;
    req_last = 4'b0001;
    req_valid = 4'b0101;
    tick();
    chk_launch("pkt.b1", 4'b0100, 8'hA1);
    req_byte[23:16] = 8'hA2;
    tx_active = 1'b1;
    tick();
    pulse_done();
    chk("pkt.c1.dv", 32'(tx_dv), 32'h0);
    chk("pkt.c1.grant", 32'(grant), 32'h4);
    tick();
    chk("pkt.c2.dv", 32'(tx_dv), 32'h0);
    tick();
    chk_launch("pkt.b2", 4'b0100, 8'hA2);
    // Last byte presented only in the done cycle itself.
    req_byte[23:16] = 8'hA3;
    req_last = 4'b0101;
    req_valid = 4'b0001;
    tx_active = 1'b1;
    tick();
    req_valid = 4'b0101;
    pulse_done();
    chk("guard.c1.dv", 32'(tx_dv), 32'h0);
    chk("guard.c1.grant", 32'(grant), 32'h4);
    tick();
    chk("guard.c2.dv", 32'(tx_dv), 32'h0);
    tick();
    chk_launch("pkt.b3", 4'b0100, 8'hA3);
    req_valid = 4'b0001;
    tx_active = 1'b1;
    tick();
    pulse_done();
    chk("pkt.rel.grant", 32'(grant), 32'h0);
    chk("pkt.rel.dv", 32'(tx_dv), 32'h0);
    tick();
    chk("pkt.idle.dv", 32'(tx_dv), 32'h0);
    tick();
    chk_launch("pkt.req0", 4'b0001, 8'h11);
    req_valid = '0;
    tx_active = 1'b1;
    tick();
    pulse_done();
    tick();

    // Timeout: pointer 1, requester 1 is served and the transmitter never completes.
    req_byte[15:8] = 8'h77;
    req_byte[31:24] = 8'h33;
    req_last = 4'b1010;
    req_valid = 4'b1010;
    tick();
    chk_launch("tmo.launch", 4'b0010, 8'h77);
    req_valid = 4'b1000;
    ready_seen = '0;
    for (int k = 1; k <= TMO - 1; k++) begin
      tick();
      ready_seen = ready_seen | req_ready;
    end
    chk("tmo.pre.timeout", 32'(timeout), 32'h0);
    chk("tmo.pre.grant", 32'(grant), 32'h2);
    chk("tmo.no_extra_ready", 32'(ready_seen), 32'h0);
    tick();
    chk("tmo.pulse", 32'(timeout), 32'h1);
    chk("tmo.grant_rel", 32'(grant), 32'h0);
    chk("tmo.ready", 32'(req_ready), 32'h0);
    tx_done = 1'b1;
    tick();
    chk("tmo.pulse_end", 32'(timeout), 32'h0);
    tick();
    tx_done = 1'b0;
    chk_launch("tmo.next", 4'b1000, 8'h33);
    req_valid = '0;
    tick();
    pulse_done();
    tick();

    // Async reset in the middle of a locked packet.
    req_byte[15:8] = 8'h5A;
    req_last = 4'b0000;
    req_valid = 4'b0010;
    tick();
    chk_launch("rst.launch", 4'b0010, 8'h5A);
    req_byte[15:8] = 8'h5B;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst.mid");
    req_byte = 32'hC3C2C1C0;
    req_last = 4'b1111;
    req_valid = 4'b1111;
    tick();
    chk_all_zero("rst.held");
    rst_n = 1'b1;

    // Fairness from pointer 0 with all requesters always valid.
    for (int r = 0; r < 6; r++) begin
      tick();
      exp_oh = 4'b0001 << (r % N);
      chk_launch($sformatf("rr%0d", r), exp_oh, 8'hC0 + 8'(r % N));
      tx_active = 1'b1;
      tick();
      pulse_done();
      chk($sformatf("rr%0d.gap1", r), 32'(tx_dv), 32'h0);
      tick();
      chk($sformatf("rr%0d.gap2", r), 32'(tx_dv), 32'h0);
    end
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance (8N1, 115200 baud at 50 MHz) between N_REQ byte producers, e.g. the sensor packetiser, status reporter and debug echo.
- Arbitrates round-robin per packet: a granted requester keeps the transmitter until it presents a byte flagged last.
- Drives the transmitter's 1-cycle data-valid pulse and byte, and consumes its done pulse.
- Enforces the inter-byte guard the transmitter needs, and recovers from a transmitter that never completes.

Parameters:
N_REQ, 4, number of requesters (2..8)
TX_TIMEOUT, 8192, clocks allowed in WAIT_DONE or WAIT_NEXT before forced release (must exceed 10*434)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous, active-low reset
i_req_valid  input  N_REQ  requester k has a byte on its lane
i_req_byte  input  8*N_REQ  lane k = bits [8k+7:8k]
i_req_last  input  N_REQ  byte on lane k ends its packet
o_req_ready  output  N_REQ  1-cycle accept pulse; byte consumed
o_grant  output  N_REQ  one-hot current owner, 0 when none
o_tx_dv  output  1  to uart_tx i_tx_dv
o_tx_byte  output  8  to uart_tx i_tx_byte
i_tx_active  input  1  from uart_tx o_tx_active
i_tx_done  input  1  from uart_tx o_tx_done
o_busy  output  1  state != IDLE
o_timeout  output  1  1-cycle pulse on forced release

Behaviour:
- Reset: async to IDLE. All outputs 0, including o_tx_byte, o_grant and o_timeout. RR pointer = 0; lock cleared; timeout counter cleared.
- All outputs are registered.

States:
- IDLE: if any i_req_valid, pick the winner by round-robin: first valid index at or after pointer, wrapping N_REQ-1 -> 0. Register o_grant, o_tx_byte = winner lane, lock = !i_req_last[winner]. Go LAUNCH. Otherwise stay.
- LAUNCH (exactly 1 cycle): o_tx_dv=1, o_req_ready[winner]=1. Go WAIT_DONE; clear counter.
- WAIT_DONE: wait for i_tx_done. On done: if lock, go WAIT_NEXT; else pointer = winner+1 (mod N_REQ), o_grant=0, go GUARD.
- WAIT_NEXT: only the owner is eligible. When i_req_valid[owner] is seen and at least 2 cycles have passed since the done cycle: capture byte and lock = !i_req_last[owner], go LAUNCH. Other requesters are ignored.
- GUARD (1 cycle) -> IDLE.

Guard rule:
- o_tx_dv is never asserted earlier than the 3rd cycle after the cycle i_tx_done is sampled high. uart_tx ignores a valid pulse in its first IDLE cycle.
- Resulting minimum done-to-dv spacing is 3 cycles, both across packets (WAIT_DONE->GUARD->IDLE->LAUNCH) and within a packet (WAIT_NEXT enforces the same count).
- Before the first byte after reset there is no guard: IDLE->LAUNCH takes 1 cycle.

Handshake and ownership:
- A requester must hold valid/byte/last stable until its o_req_ready pulse.
- o_req_ready coincides with o_tx_dv. Exactly one ready pulse per transmitted byte.
- o_grant stays stable from IDLE exit until release; it never changes mid-packet.

Timeout:
- The counter increments every cycle in WAIT_DONE and WAIT_NEXT and clears on LAUNCH.
- On reaching TX_TIMEOUT-1: o_timeout pulse, lock cleared, o_grant=0, pointer = owner+1, go GUARD.
- A late i_tx_done arriving in IDLE or GUARD is ignored.

Other rules:
- i_tx_active is monitored only: if it is not high 2 cycles after LAUNCH, latch nothing; rely on the timeout.
- Simultaneous valids resolve by pointer only. A requester deasserting valid before grant is legal and is simply not chosen.
- Counter width = $clog2(TX_TIMEOUT).
- Reset mid-transmission: all state drops immediately and o_tx_dv stays 0. The uart_tx shares the reset, so no partial handshake persists.

Test Plan:
- Single byte: req1 valid, byte 0x55, last=1 from IDLE -> o_tx_dv and o_req_ready[1] pulse together 1 cycle later, o_tx_byte=0x55, o_grant=4'b0010. Serial line shows 0x55 LSB-first. After done, grant=0 and pointer=2.
- Round-robin fairness: all 4 requesters valid continuously with single-byte packets (last=1) -> grant order 0,1,2,3,0,1. Every done-to-next-dv gap is >= 3 cycles.
- Packet lock: req2 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3) while req0 is valid throughout -> all three bytes go out before req0 is granted. o_grant constant at 4'b0100 across the packet.
- Guard check: requester presents its next byte in the same cycle as i_tx_done -> o_tx_dv rises exactly 3 cycles after the done cycle. The byte is transmitted, not dropped.
- Timeout: stub transmitter never pulses done, TX_TIMEOUT=64 -> o_timeout pulses 64 cycles after LAUNCH. Grant released, next requester served, no extra ready pulse.
- Async reset asserted mid-packet (lock held, WAIT_DONE) -> all outputs 0 immediately. After release, the first arbitration starts from pointer 0.
